path_run_sequencer: RTL

//  Sequences one path-planning run around data memory: releases the CPU, waits for cpu_done, latches the planned path, then issues nodes one at a time to the motion controller over valid/ready.
//  At the end it drives the data memory reset so memory and path registers clear for the next run.

---
 rtl/path_run_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/path_run_sequencer.sv
// path_run_sequencer
//   Runs one path-planning pass around data memory. It releases the CPU and
//   waits for cpu_done. It then latches the planned path and hands the nodes
//   one at a time to the motion controller over a valid/ready pair. Last, it
//   holds the data memory in reset until cpu_done drops, so the next run
//   starts clean.
//
// Ports
//   clk         system clock (data memory clock)
//   reset       synchronous, active-high reset
//   start       run request, sampled only while idle
//   cpu_done    data memory cpu_done flag
//   path_flat   path slots, slot 0 in [NODE_W-1:0], slot 1 next, and so on
//   path_len    node count reported by data memory
//   node_ready  motion block accepts the current node
//   node_valid  node_id / node_last are valid
//   node_id     current node
//   node_last   current node is the final node of the path
//   step        index of the node being issued
//   cpu_run     1 = CPU out of reset (cpu_reset = ~cpu_run)
//   mem_clear   drives the data memory reset input
//   busy        sequencer not idle
//   done        one-cycle pulse after a successful run
//   err         sticky error, cleared when a new start is accepted
//
// Build option
//   PATH_SEQ_TIMEOUT_EN: when defined, a watchdog forces the error state. It
//   fires after TIMEOUT_CYC cycles spent waiting in RUN_CPU, or stalled in
//   ISSUE with node_ready low.

module path_run_sequencer #(
    parameter int unsigned MAX_NODES   = 13,
    parameter int unsigned NODE_W      = 8,
    parameter logic [31:0] TIMEOUT_CYC = 32'd50000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        cpu_done,
    input  logic [MAX_NODES*NODE_W-1:0] path_flat,
    input  logic [7:0]                  path_len,
    input  logic                        node_ready,
    output logic                        node_valid,
    output logic [NODE_W-1:0]           node_id,
    output logic                        node_last,
    output logic [7:0]                  step,
    output logic                        cpu_run,
    output logic                        mem_clear,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam logic [7:0] MaxLen = 8'(MAX_NODES);

    typedef enum logic [2:0] {
        StIdle,
        StRunCpu,
        StLoad,
        StIssue,
        StClear,
        StError
    } state_e;

    state_e                      state;
    logic [MAX_NODES*NODE_W-1:0] path_q;
    logic [7:0]                  len_q;

    logic [7:0]        next_idx;
    logic [NODE_W-1:0] next_slot;
    logic              next_last;
    logic              handshake;
    logic              wd_expired;

    assign handshake = node_valid & node_ready;

    // Slot to present next: slot 0 when leaving LOAD, step+1 after a handshake.
    always_comb begin
        next_idx  = (state == StIssue) ? step + 8'd1 : 8'd0;
        next_slot = '0;
        for (int i = 0; i < MAX_NODES; i++) begin
            if (next_idx == 8'(i)) begin
                next_slot = path_q[i*NODE_W +: NODE_W];
            end
        end
        next_last = (next_idx == len_q - 8'd1);
    end

`ifdef PATH_SEQ_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        wd_run;

    // Counts only while waiting. Leaving the wait (state change or handshake)
    // drops wd_run, which clears the count.
    assign wd_run = ((state == StRunCpu && !cpu_done) ||
                     (state == StIssue && node_valid && !node_ready)) && !wd_expired;
    assign wd_expired = (wd_cnt + 32'd1 == TIMEOUT_CYC);

    always_ff @(posedge clk) begin
        if (reset || !wd_run) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 32'd1;
        end
    end
`else
    logic unused_timeout;

    assign wd_expired     = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            path_q     <= '0;
            len_q      <= '0;
            node_valid <= 1'b0;
            node_id    <= '0;
            node_last  <= 1'b0;
            step       <= '0;
            cpu_run    <= 1'b0;
            mem_clear  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state   <= StRunCpu;
                        cpu_run <= 1'b1;
                        busy    <= 1'b1;
                        err     <= 1'b0;
                    end
                end
                StRunCpu: begin
                    if (cpu_done) begin
                        state   <= StLoad;
                        cpu_run <= 1'b0;
                        path_q  <= path_flat;
                        len_q   <= path_len;
                    end else if (wd_expired) begin
                        state     <= StError;
                        cpu_run   <= 1'b0;
                        err       <= 1'b1;
                        mem_clear <= 1'b1;
                    end
                end
                StLoad: begin
                    if (len_q == 8'd0 || len_q > MaxLen) begin
                        state     <= StError;
                        err       <= 1'b1;
                        mem_clear <= 1'b1;
                    end else begin
                        state      <= StIssue;
                        step       <= 8'd0;
                        node_valid <= 1'b1;
                        node_id    <= next_slot;
                        node_last  <= next_last;
                    end
                end
                StIssue: begin
                    if (handshake) begin
                        if (node_last) begin
                            state      <= StClear;
                            node_valid <= 1'b0;
                            node_last  <= 1'b0;
                            mem_clear  <= 1'b1;
                        end else begin
                            step      <= next_idx;
                            node_id   <= next_slot;
                            node_last <= next_last;
                        end
                    end else if (wd_expired) begin
                        state      <= StError;
                        node_valid <= 1'b0;
                        node_last  <= 1'b0;
                        err        <= 1'b1;
                        mem_clear  <= 1'b1;
                    end
                end
                StClear: begin
                    if (!cpu_done) begin
                        state     <= StIdle;
                        mem_clear <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                StError: begin
                    if (!cpu_done) begin
                        state     <= StIdle;
                        mem_clear <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
